// File: rtl/mips_cpu_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single Avalon-style bus.
// One transaction in flight at a time: IDLE -> BUS -> (RDATA) -> RESP -> IDLE.
module mips_cpu_bus_arbiter #(
  parameter int TIMEOUT       = 255,
  parameter int DATA_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        read,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;

  state_t        state_q;
  logic          owner_q;       // 1 = data port owns the current transaction
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          last_grant_q;  // 1 = data port was granted last
  logic [CW-1:0] wait_q;
  logic          read_q, write_q, busy_q;
  logic          i_ack_q, d_ack_q, i_err_q, d_err_q;
  logic [31:0]   i_rdata_q, d_rdata_q;

  logic          pick_d;
  logic          req_we;
  logic [31:0]   req_addr;
  logic          bus_cmd;

  always_comb begin
    pick_d = 1'b0;
    if (d_req && i_req) pick_d = (DATA_PRIORITY != 0) ? 1'b1 : !last_grant_q;
    else if (d_req)     pick_d = 1'b1;
  end

  assign req_we   = pick_d & d_we;
  assign req_addr = pick_d ? d_addr : i_addr;

  assign bus_cmd    = read_q | write_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = bus_cmd ? addr_q  : 32'h0;
  assign writedata  = bus_cmd ? wdata_q : 32'h0;
  assign byteenable = bus_cmd ? be_q    : 4'h0;
  assign busy       = busy_q;
  assign i_ack      = i_ack_q;
  assign d_ack      = d_ack_q;
  assign i_err      = i_err_q;
  assign d_err      = d_err_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      last_grant_q <= 1'b1;
      wait_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            owner_q <= pick_d;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= pick_d ? d_wdata : 32'h0;
            be_q    <= pick_d ? d_be : 4'hf;
            wait_q  <= '0;
            busy_q  <= 1'b1;
            // Misaligned requests never reach the bus.
            if (req_addr[1:0] != 2'b00) begin
              state_q <= RESP;
              i_ack_q <= !pick_d;
              d_ack_q <= pick_d;
              i_err_q <= !pick_d;
              d_err_q <= pick_d;
            end else begin
              state_q <= BUS;
              read_q  <= !req_we;
              write_q <= req_we;
            end
          end
        end
        BUS: begin
          if (waitrequest) wait_q <= wait_q + CW'(1);
          if (!waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (we_q) begin
              state_q <= RESP;
              i_ack_q <= !owner_q;
              d_ack_q <= owner_q;
            end else begin
              state_q <= RDATA;
            end
          end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state_q <= RESP;
            i_ack_q <= !owner_q;
            d_ack_q <= owner_q;
            i_err_q <= !owner_q;
            d_err_q <= owner_q;
          end
        end
        RDATA: begin
          if (owner_q) d_rdata_q <= readdata;
          else         i_rdata_q <= readdata;
          state_q <= RESP;
          i_ack_q <= !owner_q;
          d_ack_q <= owner_q;
        end
        RESP: begin
          i_ack_q      <= 1'b0;
          d_ack_q      <= 1'b0;
          i_err_q      <= 1'b0;
          d_err_q      <= 1'b0;
          busy_q       <= 1'b0;
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
